// File: rtl/ring_addr_seq.sv
// -----------------------------------------------------------------------------
// ring_addr_seq
//   Address sequencer for the digitizer ring buffer. While armed it produces the
//   RAM write address for every ADC sample, captures the ring position of the
//   trigger, counts the post-trigger samples, then plays a block of ring
//   addresses out to the readout logic over a valid/ready handshake.
//
//   Optional feature (compile-time macro):
//     RING_ADDR_SEQ_AUTOARM_EN  defined     : DONE re-arms directly (ARM, fill=0)
//                               not defined : DONE -> IDLE, a trig pulse re-arms
//
// Parameters
//   AW     address width; also the width of pre_i, post_i, len_i
//   DEPTH  ring depth in samples, 2 <= DEPTH <= 2**AW, any value (not only 2**n)
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   wr_en     in   1   ADC sample strobe
//   trig      in   1   trigger pulse (captured in ARM, re-arms from IDLE)
//   pre_i     in   AW  pre-trigger samples to replay (latched at trigger)
//   post_i    in   AW  post-trigger samples to write (latched at trigger)
//   len_i     in   AW  total samples to read out (latched at trigger)
//   wr_addr   out  AW  RAM write address
//   wr_we     out  1   RAM write enable
//   rd_addr   out  AW  RAM read address, valid when rd_valid
//   rd_valid  out  1   rd_addr is valid
//   rd_ready  in   1   consumer accepts rd_addr this cycle
//   rd_last   out  1   final address of the block
//   busy      out  1   high in POST or READ
//   done      out  1   one-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module ring_addr_seq #(
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic          trig,
   input  logic [AW-1:0] pre_i,
   input  logic [AW-1:0] post_i,
   input  logic [AW-1:0] len_i,
   output logic [AW-1:0] wr_addr,
   output logic          wr_we,
   output logic [AW-1:0] rd_addr,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic          rd_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      ARM  = 3'd0,
      POST = 3'd1,
      READ = 3'd2,
      DONE = 3'd3,
      IDLE = 3'd4
   } state_t;

   // Ring depth held one bit wider than an address so DEPTH == 2**AW is representable.
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t        state, state_nxt;
   logic [AW:0]   fill;          // writes since arm, saturates at DEPTH
   logic [AW-1:0] trig_addr;
   logic [AW-1:0] eff_pre;
   logic [AW-1:0] eff_len;
   logic [AW-1:0] post_cnt;
   logic [AW-1:0] remaining;

   logic [AW-1:0] pre_clip;
   logic [AW-1:0] len_clip;
   logic [AW-1:0] start_base;
   logic [AW-1:0] start_pre;
   logic [AW:0]   start_sum;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] start_len;
   logic          hs;
   logic          enter_read;
   logic          arming;

   // Increment modulo DEPTH; the wrap point is compared explicitly so a
   // non-power-of-two ring never relies on natural binary overflow.
   function automatic logic [AW-1:0] inc_mod(input logic [AW-1:0] a);
      return ({1'b0, a} == DEPTH_W - 1'b1) ? '0 : a + 1'b1;
   endfunction

   // -------------------------------------------------------------------------
   // Outputs decoded from state
   // -------------------------------------------------------------------------
   assign wr_we    = wr_en && (state == ARM || state == POST);
   assign rd_valid = (state == READ);
   assign rd_last  = rd_valid && (remaining == AW'(1));
   assign busy     = (state == POST) || (state == READ);
   assign done     = (state == DONE);
   assign hs       = rd_valid && rd_ready;

   // -------------------------------------------------------------------------
   // Trigger-time clipping and readout start address
   // -------------------------------------------------------------------------
   // Only samples actually written since arm can be replayed; the clipped value
   // never exceeds pre_i, so it always fits in AW bits.
   assign pre_clip = ({1'b0, pre_i} < fill)    ? pre_i : AW'(fill);
   // A block longer than the ring would replay addresses twice.
   assign len_clip = ({1'b0, len_i} < DEPTH_W) ? len_i : AW'(DEPTH);

   // READ can be entered straight from ARM (post_i == 0), when the trigger
   // registers are being loaded in that same cycle, so use the live values then.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      start_base = trig_addr;
      start_pre  = eff_pre;
      start_len  = eff_len;
      if (state == ARM) begin
         start_base = wr_addr;
         start_pre  = pre_clip;
         start_len  = len_clip;
      end
      // (base - pre) mod DEPTH computed as base + DEPTH - pre in AW+1 bits, then one conditional subtract.
      start_sum  = {1'b0, start_base} + DEPTH_W - {1'b0, start_pre};
      start_addr = (start_sum >= DEPTH_W) ? AW'(start_sum - DEPTH_W) : AW'(start_sum);
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         ARM: begin
            if (trig) begin
               if (post_i != '0)      state_nxt = POST;
               else if (len_clip != '0) state_nxt = READ;
               else                   state_nxt = DONE;
            end
         end
         POST: begin
            if (wr_we && post_cnt == AW'(1)) begin
               state_nxt = (eff_len != '0) ? READ : DONE;
            end
         end
         READ: begin
            if (hs && rd_last) state_nxt = DONE;
         end
         DONE: begin
`ifdef RING_ADDR_SEQ_AUTOARM_EN
            state_nxt = ARM;
`else
            state_nxt = IDLE;
`endif
         end
         IDLE: begin
            if (trig) state_nxt = ARM;
         end
         default: state_nxt = ARM;
      endcase
   end

   assign enter_read = (state_nxt == READ) && (state != READ);
   assign arming     = (state_nxt == ARM)  && (state != ARM);

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARM;
         wr_addr   <= '0;
         fill      <= '0;
         trig_addr <= '0;
         eff_pre   <= '0;
         eff_len   <= '0;
         post_cnt  <= '0;
         remaining <= '0;
         rd_addr   <= '0;
      end else begin
         state <= state_nxt;

         if (wr_we) wr_addr <= inc_mod(wr_addr);

         if (arming)                          fill <= '0;
         else if (wr_we && fill != DEPTH_W)   fill <= fill + 1'b1;

         if (state == ARM && trig) begin
            trig_addr <= wr_addr;
            eff_pre   <= pre_clip;
            eff_len   <= len_clip;
            post_cnt  <= post_i;
         end else if (state == POST && wr_we) begin
            post_cnt  <= post_cnt - 1'b1;
         end

         if (enter_read) begin
            rd_addr   <= start_addr;
            remaining <= start_len;
         end else if (hs) begin
            rd_addr   <= inc_mod(rd_addr);
            remaining <= remaining - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ring_addr_seq.sv
// -----------------------------------------------------------------------------
// tb_ring_addr_seq
//   Directed bench for ring_addr_seq. Two instances share every input: one with
//   DEPTH=256 (a_*) and one with a non-power-of-two DEPTH=200 (b_*), so each
//   stimulus sequence exercises both wrap behaviours. Inputs are driven just
//   after the rising edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_ring_addr_seq;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic          trig;
   logic [AW-1:0] pre_i;
   logic [AW-1:0] post_i;
   logic [AW-1:0] len_i;
   logic          rd_ready;

   logic [AW-1:0] a_wr_addr, a_rd_addr, b_wr_addr, b_rd_addr;
   logic          a_wr_we, a_rd_valid, a_rd_last, a_busy, a_done;
   logic          b_wr_we, b_rd_valid, b_rd_last, b_busy, b_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ring_addr_seq #(.AW(AW), .DEPTH(256)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .trig(trig),
      .pre_i(pre_i), .post_i(post_i), .len_i(len_i),
      .wr_addr(a_wr_addr), .wr_we(a_wr_we), .rd_addr(a_rd_addr),
      .rd_valid(a_rd_valid), .rd_ready(rd_ready), .rd_last(a_rd_last),
      .busy(a_busy), .done(a_done)
   );

   ring_addr_seq #(.AW(AW), .DEPTH(200)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .trig(trig),
      .pre_i(pre_i), .post_i(post_i), .len_i(len_i),
      .wr_addr(b_wr_addr), .wr_we(b_wr_we), .rd_addr(b_rd_addr),
      .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_last(b_rd_last),
      .busy(b_busy), .done(b_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      trig     = 1'b0;
      rd_ready = 1'b0;
      pre_i    = '0;
      post_i   = '0;
      len_i    = '0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Arm with n writes, then a trigger cycle with wr_en low and post_i=0.
   task automatic prime_and_trig(input int n, input int pre, input int len);
      wr_en = 1'b1;
      repeat (n) step();
      wr_en  = 1'b0;
      trig   = 1'b1;
      pre_i  = AW'(pre);
      post_i = '0;
      len_i  = AW'(len);
      step();
      trig = 1'b0;
   endtask

   logic bp_ready [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   int   bp_addr  [6] = '{1, 2, 2, 2, 3, 4};

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_wr_addr",  a_wr_addr,  0);
      check("rst_wr_we",    a_wr_we,    0);
      check("rst_rd_valid", a_rd_valid, 0);
      check("rst_rd_last",  a_rd_last,  0);
      check("rst_busy",     a_busy,     0);
      check("rst_done",     a_done,     0);
      check("rst_rd_addr",  a_rd_addr,  0);
      rst_n = 1'b1;
      step();

      // ---------------- 300 writes, trig at 44, pre 10, post 5, len 20 ----------------
      wr_en = 1'b1;
      repeat (300) step();
      check("wrap_a_wr_addr", a_wr_addr, 44);
      check("wrap_b_wr_addr", b_wr_addr, 100);
      trig = 1'b1; pre_i = 8'd10; post_i = 8'd5; len_i = 8'd20;
      #1;
      check("trig_wr_we", a_wr_we, 1);
      step();
      trig = 1'b0;
      for (int i = 0; i < 5; i++) begin
         // A trigger during POST with different settings must be ignored.
         trig = (i == 2);
         pre_i = (i == 2) ? 8'd0 : 8'd10;
         len_i = (i == 2) ? 8'd3 : 8'd20;
         #1;
         check("post_wr_we",    a_wr_we,    1);
         check("post_wr_addr",  a_wr_addr,  45 + i);
         check("post_busy",     a_busy,     1);
         check("post_rd_valid", a_rd_valid, 0);
         step();
      end
      trig = 1'b0;
      rd_ready = 1'b1;
      #1;
      check("read_wr_we_off", a_wr_we,   0);
      check("read_wr_addr",   a_wr_addr, 50);
      for (int i = 0; i < 20; i++) begin
         check("t2_rd_valid", a_rd_valid, 1);
         check("t2_rd_addr",  a_rd_addr,  34 + i);
         check("t2_rd_last",  a_rd_last,  (i == 19));
         check("t2_b_rd_addr", b_rd_addr, 90 + i);
         check("t2_done_low", a_done,     0);
         step();
      end
      check("t2_done",     a_done,     1);
      check("t2_b_done",   b_done,     1);
      check("t2_done_vld", a_rd_valid, 0);
      check("t2_done_bsy", a_busy,     0);
      step();
      check("t2_done_pulse", a_done, 0);
`ifdef RING_ADDR_SEQ_AUTOARM_EN
      check("t2_rearm_we", a_wr_we, 1);
`else
      check("t2_idle_we",  a_wr_we, 0);
`endif

      // ---------------- non-pow2 wrap: trig at b addr 3, pre 8, len 12 ----------------
      do_reset();
      wr_en = 1'b1;
      repeat (203) step();
      check("t3_b_wr_addr", b_wr_addr, 3);
      prime_and_trig(0, 8, 12);
      rd_ready = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) begin
         check("t3_b_rd_addr", b_rd_addr, (195 + i) % 200);
         check("t3_b_rd_last", b_rd_last, (i == 11));
         check("t3_a_rd_addr", a_rd_addr, 195 + i);
         step();
      end
      check("t3_b_done", b_done, 1);
      check("t3_a_done", a_done, 1);

      // ---------------- not primed: 4 writes, pre 10, len 6 ----------------
      do_reset();
      prime_and_trig(4, 10, 6);
      rd_ready = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         check("t4_rd_addr", a_rd_addr, i);
         check("t4_rd_last", a_rd_last, (i == 5));
         step();
      end
      check("t4_done", a_done, 1);

      // ---------------- len > DEPTH and pre > fill clipping ----------------
      // b: fill 200, trig at 10 -> start 10, 200 addresses. a: fill 210 -> start 0, 250 addresses.
      do_reset();
      prime_and_trig(210, 255, 250);
      rd_ready = 1'b1;
      #1;
      for (int i = 0; i < 250; i++) begin
         check("clip_a_rd_addr", a_rd_addr, i);
         check("clip_a_rd_last", a_rd_last, (i == 249));
         if (i < 200) begin
            check("clip_b_rd_addr", b_rd_addr, (10 + i) % 200);
            check("clip_b_rd_last", b_rd_last, (i == 199));
         end else if (i == 200) begin
            check("clip_b_done", b_done, 1);
         end
         step();
      end
      check("clip_a_done", a_done, 1);

      // ---------------- backpressure: 4 writes, pre 3, len 4 ----------------
      do_reset();
      rd_ready = 1'b1;   // ready without valid must be harmless
      prime_and_trig(4, 3, 4);
      for (int i = 0; i < 6; i++) begin
         rd_ready = bp_ready[i];
         #1;
         check("bp_rd_valid", a_rd_valid, 1);
         check("bp_rd_addr",  a_rd_addr,  bp_addr[i]);
         check("bp_rd_last",  a_rd_last,  (i == 5));
         step();
      end
      check("bp_done", a_done, 1);

      // ---------------- len 0: POST then DONE, no readout ----------------
      do_reset();
      wr_en = 1'b1;
      repeat (3) step();
      trig = 1'b1; pre_i = 8'd2; post_i = 8'd2; len_i = 8'd0;
      step();
      trig = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("len0_post_we",  a_wr_we,    1);
         check("len0_rd_valid", a_rd_valid, 0);
         step();
      end
      check("len0_done",     a_done,     1);
      check("len0_rd_valid", a_rd_valid, 0);
      check("len0_we_off",   a_wr_we,    0);
      step();
      check("len0_done_pulse", a_done,     0);
      check("len0_rd_valid2",  a_rd_valid, 0);
`ifdef RING_ADDR_SEQ_AUTOARM_EN
      check("len0_autoarm_we", a_wr_we, 1);
`else
      check("len0_idle_we", a_wr_we, 0);
      step();
      check("len0_idle_hold", a_wr_we, 0);
      trig = 1'b1;
      step();
      trig = 1'b0;
      #1;
      check("len0_rearm_we",   a_wr_we, 1);
      check("len0_rearm_busy", a_busy,  0);
      step();
      check("len0_no_capture", a_busy,  0);
`endif

      // ---------------- reset mid-READ ----------------
      do_reset();
      prime_and_trig(4, 2, 6);
      rd_ready = 1'b0;
      step();
      check("mid_rd_valid", a_rd_valid, 1);
      check("mid_busy",     a_busy,     1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid",   a_rd_valid, 0);
      check("mid_rst_busy",    a_busy,     0);
      check("mid_rst_wr_addr", a_wr_addr,  0);
      check("mid_rst_done",    a_done,     0);
      step();
      rst_n = 1'b1;
      wr_en = 1'b1;
      #1;
      check("mid_arm_we",   a_wr_we, 1);
      check("mid_arm_busy", a_busy,  0);
      step();
      check("mid_arm_done", a_done,  0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
